// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared types and constants for the pipeline flow controller and its MD busy tracker.
// Holds the interrupt FSM encoding and the MD countdown width.
package cpu_ctrl_pkg;

   localparam int MD_CNT_W       = 6;
   localparam int MUL_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 32;

   typedef enum logic [1:0] {
      I_IDLE = 2'd0,
      I_PEND = 2'd1,
      I_TAKE = 2'd2
   } irq_state_t;

   // Clamp a latency parameter into the range the 6-bit countdown can represent.
   function automatic logic [MD_CNT_W-1:0] md_latency(input int cycles);
      int c;
      c = cycles;
      if (c < 1) c = 1;
      if (c > (1 << MD_CNT_W) - 1) c = (1 << MD_CNT_W) - 1;
      return MD_CNT_W'(c);
   endfunction

endpackage

// File: rtl/pipe_flow_ctrl_md_busy_tracker.sv
// Countdown model of the multi-cycle MUL/DIV unit.
// Produces md_busy and the stall raised when ID needs HI/LO while the unit computes.
module md_busy_tracker
   import cpu_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic md_start_mul_i,
   input  logic md_start_div_i,
   input  logic id_uses_md_i,
   output logic md_busy_o,
   output logic md_stall_o
);

   localparam logic [MD_CNT_W-1:0] MUL_LD = md_latency(MUL_CYCLES);
   localparam logic [MD_CNT_W-1:0] DIV_LD = md_latency(DIV_CYCLES);

   logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

   // A start while busy is illegal and deliberately ignored; div has priority over mul.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - 1'b1;
      end else if (md_start_div_i) begin
         md_cnt_d = DIV_LD;
      end else if (md_start_mul_i) begin
         md_cnt_d = MUL_LD;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign md_busy_o  = (md_cnt_q != '0);
   assign md_stall_o = md_busy_o & id_uses_md_i;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: stall/flush generation, deferred interrupt entry and
// a saturating stall-cycle statistics counter.
module pipe_flow_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int NUM_IRQ    = 6,
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld_use_stall,
   input  logic               gpr_stall,
   input  logic               id_uses_md,
   input  logic               id_is_cti,
   input  logic               md_start_mul,
   input  logic               md_start_div,
   input  logic               correct_at_ex,
   input  logic               correct_at_mem,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               ie,
   input  logic               exl,
   input  logic               stat_clr,
   output logic               pc_write,
   output logic               if_flush,
   output logic               id_flush,
   output logic               exl_set,
   output logic [NUM_IRQ-1:0] irq_cause,
   output logic               md_busy,
   output logic [CNT_W-1:0]   stall_cnt,
   output irq_state_t         dbg_irq_state
);

   logic               md_stall;
   logic               stall;
   logic [NUM_IRQ-1:0] irq_src;
   logic               irq_hit;
   logic               take_ok;
   logic               exl_set_c;

   irq_state_t         state_q, state_d;
   logic [NUM_IRQ-1:0] cause_q, cause_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   md_busy_tracker #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md (
      .clk_i          (clk),
      .rst_i          (reset),
      .md_start_mul_i (md_start_mul),
      .md_start_div_i (md_start_div),
      .id_uses_md_i   (id_uses_md),
      .md_busy_o      (md_busy),
      .md_stall_o     (md_stall)
   );

   assign stall    = ld_use_stall | gpr_stall | md_stall;
   assign pc_write = ~stall;
   assign if_flush = exl_set_c | correct_at_ex | correct_at_mem;
   assign id_flush = stall | correct_at_mem;

   assign irq_src = irq_in & irq_mask;
   assign irq_hit = (irq_src != '0) & ie & ~exl;
   // Entry is held off over a CTI so EPC never lands in a delay slot.
   assign take_ok = ~id_is_cti & ~stall & ~correct_at_ex & ~correct_at_mem;

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      exl_set_c = 1'b0;
      case (state_q)
         I_IDLE: begin
            if (irq_hit) begin
               state_d = I_PEND;
               cause_d = irq_src;
            end
         end
         I_PEND: begin
            cause_d = irq_src;
            if ((irq_src == '0) || exl || !ie) begin
               state_d = I_IDLE;
            end else if (take_ok) begin
               exl_set_c = 1'b1;
               state_d   = I_TAKE;
            end
         end
         // One dead cycle lets the CP0 EXL write become visible before re-arming.
         I_TAKE: begin
            state_d = I_IDLE;
         end
         default: begin
            state_d = I_IDLE;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stat_clr) begin
         stall_cnt_d = '0;
      end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= I_IDLE;
         cause_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign exl_set       = exl_set_c;
   assign irq_cause     = cause_q;
   assign stall_cnt     = stall_cnt_q;
   assign dbg_irq_state = state_q;

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Sequential successor to the pipeline controller's hazard and flush logic. It adds a multi-cycle MUL/DIV busy tracker, a deferred-interrupt state machine that never drops an IRQ arriving over a control-transfer instruction, per-source IRQ masking, and a saturating stall-cycle counter.
- Sits beside the instruction decoder.
- Consumes stall and branch-correction requests; drives PC write enable, IF/ID flush and the CP0 EXL-set strobe.

Parameters:
- NUM_IRQ, 6, number of hardware interrupt lines.
- MUL_CYCLES, 5, EX-to-result latency of mult/multu (range 1..63).
- DIV_CYCLES, 32, latency of div/divu (range 1..63).
- CNT_W, 32, width of the stall statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ld_use_stall  in  1  load-use hazard request from the stall detector.
- gpr_stall  in  1  jr/jalr or branch operand hazard request.
- id_uses_md  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu.
- id_is_cti  in  1  ID instruction is a branch or jump (j/jal/jr/jalr/any branchType≠0).
- md_start_mul  in  1  mult/multu entering EX this cycle.
- md_start_div  in  1  div/divu entering EX this cycle.
- correct_at_ex  in  1  branch misprediction corrected at EX.
- correct_at_mem  in  1  branch misprediction corrected at MEM.
- irq_in  in  NUM_IRQ  level interrupt lines.
- irq_mask  in  NUM_IRQ  CP0 IM field.
- ie  in  1  CP0 global interrupt enable.
- exl  in  1  CP0 EXL bit.
- stat_clr  in  1  synchronous clear of stall_cnt.
- pc_write  out  1  PC write enable.
- if_flush  out  1  flush IF/ID register.
- id_flush  out  1  flush ID/EX register (bubble insert).
- exl_set  out  1  one-cycle strobe: take interrupt, set EXL, redirect PC.
- irq_cause  out  NUM_IRQ  latched pending sources for CP0 Cause.IP.
- md_busy  out  1  MD unit computing.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async) values:
  - FSM = I_IDLE; md_cnt = 0; irq_cause = 0; stall_cnt = 0.
  - Outputs under reset with all inputs 0: pc_write=1, flushes=0, exl_set=0, md_busy=0.
- MD tracker:
  - md_cnt, 6 bits. md_start_mul loads MUL_CYCLES; md_start_div loads DIV_CYCLES; otherwise decrements while nonzero.
  - md_busy = (md_cnt≠0).
  - A start while md_busy=1 is ignored, and no reload occurs; the protocol forbids this case.
  - Both starts in one cycle: div wins.
  - md_stall = md_busy & id_uses_md.
- Stall and flush (combinational, same cycle as inputs):
  - stall = ld_use_stall | gpr_stall | md_stall.
  - pc_write = ~stall.
  - if_flush = exl_set | correct_at_ex | correct_at_mem.
  - id_flush = stall | correct_at_mem.
- Interrupt FSM:
  - irq_hit = (irq_in & irq_mask) ≠ 0, ANDed with ie and ~exl.
  - take_ok = ~id_is_cti & ~stall & ~correct_at_ex & ~correct_at_mem.
  - I_IDLE: irq_hit → I_PEND, irq_cause <= irq_in & irq_mask.
  - I_PEND:
    - irq_cause refreshes every cycle to irq_in & irq_mask.
    - If that value is 0, or exl=1, or ie=0 → I_IDLE with no strobe (withdrawn).
    - Else if take_ok: exl_set=1 this cycle (combinational) → I_TAKE.
    - Else stay in I_PEND (deferred over a CTI, stall or correction).
  - I_TAKE: exactly one cycle; exl_set=0; irq_cause held → I_IDLE. This guards against re-triggering before CP0 EXL is visible.
  - exl_set is never asserted in I_IDLE. An IRQ therefore has a minimum 1-cycle latency from irq_in to exl_set.
  - exl_set and a branch correction are never asserted in the same cycle.
- stall_cnt:
  - Increments when stall=1; saturates at all-ones.
  - stat_clr has priority over increment; the value is 0 on the next cycle.
- Reset mid-operation:
  - Abandons any MD countdown and pending IRQ.
  - No exl_set is produced after reset deassertion unless a new irq_hit occurs.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - enum irq_state_t {I_IDLE, I_PEND, I_TAKE}.
  - MD_CNT_W=6 and default MUL/DIV latencies.
- Sub-module md_busy_tracker: counter, md_busy, md_stall.
- The IRQ FSM and stall_cnt stay in the top module.

Test Plan:
- md_start_mul at t0 (MUL_CYCLES=5), id_uses_md=1 from t1 → md_busy=1 t1..t5, stall=1/pc_write=0/id_flush=1 t1..t5, pc_write=1 at t6. stall_cnt=5.
- irq_in=6'b000100, mask=6'b111111, ie=1, exl=0 at t0, id_is_cti=0 → I_PEND t1, exl_set=1 and if_flush=1 at t1, irq_cause=000100, I_TAKE t2, I_IDLE t3.
- As above but id_is_cti=1 at t1..t2 → exl_set=0 t1..t2, exl_set=1 at t3, exactly one pulse.
- irq_in pulses 1 cycle at t0 then 0 → I_PEND t1, irq_cause refreshes to 0, I_IDLE t2, exl_set never asserted.
- correct_at_mem=1 with ld_use_stall=1 → if_flush=1, id_flush=1, pc_write=0; pending IRQ deferred until both are low.
- div started, reset asserted at cycle 3 → md_busy=0, stall_cnt=0 immediately. stall_cnt at all-ones plus stall stays all-ones; stat_clr → 0 next cycle.
